// File: rtl/relay_seq_pkg.sv
// relay_seq_pkg: shared sequencer types; the BREAK state exists only when RELAY_SEQ_MUTEX_EN is defined
package relay_seq_pkg;
  localparam int MAX_CH = 16;
  localparam int SETTLE_DEF = 16;
  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
`ifdef RELAY_SEQ_MUTEX_EN
    BREAK,
`endif
    SETTLE,
    DONE
  } state_t;
endpackage

// File: rtl/relay_seq_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      idx = req[IW'((int'(ptr) + i) % N)] ? IW'((int'(ptr) + i) % N) : idx;
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/relay_seq_ctrl.sv
// relay_seq_ctrl: round-robin relay coil sequencer with settle hold; RELAY_SEQ_MUTEX_EN adds break-before-make exclusivity
module relay_seq_ctrl
  import relay_seq_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SETTLE_CYC = SETTLE_DEF,
  parameter int CNT_W = 8,
  localparam int IW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [IW-1:0]   req_ch,
  input  logic            req_on,
  output logic            req_ready,
  output logic [N_CH-1:0] coil_drv,
  output logic [N_CH-1:0] sw_state,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   done_ch,
  output logic            err
);
  if (SETTLE_CYC < 1 || SETTLE_CYC > 2**CNT_W - 1) begin : g_bad_settle
    $error("SETTLE_CYC must lie in 1..2**CNT_W-1");
  end
  if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_nch
    $error("N_CH must lie in 2..16");
  end
  state_t state, nxt;
  logic [N_CH-1:0] pend, tgt, gnt, acc_oh;
  logic [IW-1:0] rr_ptr, cur, gidx, ent_idx;
  logic [CNT_W-1:0] cnt;
  logic accept, gany, cur_on, ent_on, cnt_zero, load;
  rr_arbiter #(.N(N_CH)) u_arb (.req(pend), .ptr(rr_ptr), .gnt(gnt), .idx(gidx), .any(gany));
  assign req_ready = int'(req_ch) < N_CH;
  assign accept = req_valid && req_ready;
  assign acc_oh = accept ? N_CH'(1) << req_ch : '0;
  assign cnt_zero = cnt == '0;
  assign ent_idx = state == GRANT ? gidx : cur;
  assign ent_on = state == GRANT ? tgt[gidx] : cur_on;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign done_ch = cur;
`ifdef RELAY_SEQ_MUTEX_EN
  logic [N_CH-1:0] brk;
  assign brk = sw_state & ~(state == GRANT ? gnt : N_CH'(1) << cur);
  assign load = nxt != state && (nxt == SETTLE || nxt == BREAK);
`else
  assign load = nxt != state && nxt == SETTLE;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = gany ? GRANT : IDLE;
      GRANT:  nxt = tgt[gidx] == sw_state[gidx] ? DONE :
`ifdef RELAY_SEQ_MUTEX_EN
                    tgt[gidx] && |brk ? BREAK :
`endif
                    SETTLE;
`ifdef RELAY_SEQ_MUTEX_EN
      BREAK:  nxt = cnt_zero ? SETTLE : BREAK;
`endif
      SETTLE: nxt = cnt_zero ? DONE : SETTLE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      tgt <= '0;
      coil_drv <= '0;
      sw_state <= '0;
      rr_ptr <= '0;
      cur <= '0;
      cur_on <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      err <= err | (req_valid & ~req_ready);
      // an accept to the channel being granted re-arms its pend bit
      pend <= (pend & ~(state == GRANT ? gnt : '0)) | acc_oh;
      tgt <= req_on ? tgt | acc_oh : tgt & ~acc_oh;
      if (state == GRANT) begin
        cur <= gidx;
        cur_on <= tgt[gidx];
        rr_ptr <= gidx == IW'(N_CH - 1) ? '0 : gidx + 1'b1;
      end
      if (nxt == SETTLE && state != SETTLE) coil_drv[ent_idx] <= ent_on;
`ifdef RELAY_SEQ_MUTEX_EN
      if (nxt == BREAK && state != BREAK) coil_drv <= coil_drv & ~brk;
      if (state == BREAK && nxt != BREAK) sw_state <= sw_state & ~brk;
`endif
      if (state == DONE) sw_state[cur] <= coil_drv[cur];
      cnt <= load ? CNT_W'(SETTLE_CYC - 1) : cnt_zero ? cnt : cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_relay_seq_ctrl.sv
// tb_relay_seq_ctrl: timeline-model bench for relay_seq_ctrl plus a 5-channel instance for range errors
module tb_relay_seq_ctrl;
  localparam int N = 4;
  localparam int S = 16;
`ifdef RELAY_SEQ_MUTEX_EN
  localparam bit MUTEX = 1'b1;
`else
  localparam bit MUTEX = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid = 1'b0, req_on = 1'b0;
  logic [1:0] req_ch = '0;
  logic req_ready, busy, done, err;
  logic [3:0] coil_drv, sw_state;
  logic [1:0] done_ch;
  logic r2_valid = 1'b0, r2_on = 1'b0;
  logic [2:0] r2_ch = '0;
  logic ready2, busy2, done2, err2;
  logic [4:0] coil2, sw2;
  logic [2:0] dch2;
  int checks = 0, errors = 0, cyc = 0;
  int dq[$], dc[$];

  relay_seq_ctrl #(.N_CH(N), .SETTLE_CYC(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ch(req_ch), .req_on(req_on),
    .req_ready(req_ready), .coil_drv(coil_drv), .sw_state(sw_state), .busy(busy),
    .done(done), .done_ch(done_ch), .err(err));

  relay_seq_ctrl #(.N_CH(5), .SETTLE_CYC(3), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ch(r2_ch), .req_on(r2_on),
    .req_ready(ready2), .coil_drv(coil2), .sw_state(sw2), .busy(busy2),
    .done(done2), .done_ch(dch2), .err(err2));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Model: each grant schedules absolute cycles for coil change, break release and done
  logic [3:0] m_pend, m_tgt, m_coil, m_sw, m_brk;
  logic [1:0] m_ptr, m_cur, ch, j;
  bit m_on, m_act, m_err, pre_act, found;
  int t_g, t_make, t_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_tgt = '0; m_coil = '0; m_sw = '0; m_brk = '0; m_ptr = '0; m_cur = '0;
      m_on = 0; m_act = 0; m_err = 0; t_g = -100; t_make = -100; t_done = -100;
    end else begin
      pre_act = m_act;
      cyc++;
      if (pre_act && cyc == t_g + 1) begin
        found = 0;
        ch = '0;
        for (int i = 0; i < N; i++) begin
          j = m_ptr + 2'(i);
          if (!found && m_pend[j]) begin found = 1; ch = j; end
        end
        m_cur = ch;
        m_ptr = ch + 2'd1;
        m_pend[ch] = 1'b0;
        m_on = m_tgt[ch];
        m_brk = (MUTEX && m_on) ? m_sw & ~(4'd1 << ch) : 4'd0;
        t_make = -100;
        if (m_on == m_sw[ch]) t_done = cyc;
        else if (m_brk != 0) begin m_coil &= ~m_brk; t_make = cyc + S; t_done = cyc + 2 * S; end
        else begin m_coil[ch] = m_on; t_done = cyc + S; end
      end
      if (pre_act && cyc == t_make) begin m_sw &= ~m_brk; m_coil[m_cur] = m_on; end
      if (pre_act && cyc == t_done + 1) begin m_sw[m_cur] = m_coil[m_cur]; m_act = 0; end
      if (!pre_act && m_pend != 0) begin m_act = 1; t_g = cyc; end
      if (req_valid) begin
        if (int'(req_ch) < N) begin m_pend[req_ch] = 1'b1; m_tgt[req_ch] = req_on; end
        else m_err = 1;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("req_ready", req_ready, 32'(int'(req_ch) < N));
    chk("busy", busy, m_act);
    chk("done", done, m_act && cyc == t_done);
    if (done) chk("done_ch", done_ch, m_cur);
    chk("coil_drv", coil_drv, m_coil);
    chk("sw_state", sw_state, m_sw);
    chk("err", err, m_err);
    if (done) begin dq.push_back(int'(done_ch)); dc.push_back(cyc); end
  end

  task automatic req(input logic [1:0] c, input logic on, output int t);
    @(negedge clk); #1 req_valid = 1'b1; req_ch = c; req_on = on;
    @(negedge clk); t = cyc; #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((m_act || m_pend != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic chk_order(string name, int a, int b, int c);
    chk({name, "_count"}, dq.size(), 3);
    if (dq.size() == 3) begin
      chk({name, "_0"}, dq[0], a);
      chk({name, "_1"}, dq[1], b);
      chk({name, "_2"}, dq[2], c);
    end
  endtask

  initial begin
    int t;
    logic [3:0] snap;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    logic [3:0] snap;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_coil", coil_drv, 0); chk("rst_sw", sw_state, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_done_ch", done_ch, 0); chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    // close ch2: coil two cycles after accept, done S cycles later
    req(2'd2, 1'b1, t);
    @(negedge clk); chk("ch2_coil_t1", coil_drv, 4'b0000);
    @(negedge clk); chk("ch2_coil_t2", coil_drv, 4'b0100);
    wait_idle();
    chk("ch2_count", dq.size(), 1);
    if (dq.size() == 1) begin chk("ch2_done_ch", dq[0], 2); chk("ch2_done_cyc", dc[0], t + 2 + S); end
    chk("ch2_sw", sw_state, 4'b0100);
    dq.delete(); dc.delete();
    // reset in the middle of a settle hold
    req(2'd3, 1'b1, t);
    repeat (5) @(negedge clk);
    chk("mid_coil", coil_drv, MUTEX ? 4'b0000 : 4'b1100);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_coil", coil_drv, 0); chk("async_busy", busy, 0); chk("async_sw", sw_state, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    dq.delete(); dc.delete();
    // round robin from pointer 0
    req(2'd0, 1'b1, t); req(2'd1, 1'b1, t); req(2'd3, 1'b1, t);
    wait_idle();
    chk_order("rr_a", 0, 1, 3);
    chk("rr_a_sw", sw_state, MUTEX ? 4'b1000 : 4'b1011);
    dq.delete(); dc.delete();
    // ch0 and ch3 queue behind ch1; pointer now sits at 2
    req(2'd1, 1'b0, t);
    repeat (3) @(negedge clk);
    req(2'd0, 1'b0, t); req(2'd3, 1'b0, t);
    wait_idle();
    if (MUTEX) chk_order("rr_b", 1, 0, 3); else chk_order("rr_b", 1, 3, 0);
    chk("rr_b_sw", sw_state, 4'b0000);
    dq.delete(); dc.delete();
    // ch1 on then off before its grant collapses to one no-op completion
    req(2'd2, 1'b1, t); req(2'd1, 1'b1, t); req(2'd1, 1'b0, t);
    wait_idle();
    chk("lw_count", dq.size(), 2);
    if (dq.size() == 2) begin chk("lw_first", dq[0], 2); chk("lw_second", dq[1], 1); end
    chk("lw_sw", sw_state, 4'b0100);
    chk("lw_coil", coil_drv, 4'b0100);
    // closing an already-closed channel completes without a settle
    req(2'd1, 1'b1, t);
    wait_idle();
    chk("noop_pre_sw", sw_state, MUTEX ? 4'b0010 : 4'b0110);
    dq.delete(); dc.delete();
    snap = coil_drv;
    req(2'd1, 1'b1, t);
    wait_idle();
    chk("noop_count", dq.size(), 1);
    if (dq.size() == 1) begin chk("noop_ch", dq[0], 1); chk("noop_cyc", dc[0], t + 2); end
    chk("noop_coil", coil_drv, snap);
    // out-of-range channel on the 5-channel instance
    @(negedge clk); #1 r2_valid = 1'b1; r2_ch = 3'd5; r2_on = 1'b1;
    @(negedge clk); chk("oor_ready5", ready2, 0); chk("oor_err", err2, 1);
    #1 r2_ch = 3'd7;
    @(negedge clk); chk("oor_ready7", ready2, 0); chk("oor_busy", busy2, 0);
    #1 r2_valid = 1'b0; r2_ch = 3'd4;
    repeat (3) @(negedge clk);
    chk("oor_ready4", ready2, 1); chk("oor_sticky", err2, 1);
    chk("oor_sw", sw2, 0); chk("oor_coil", coil2, 0); chk("oor_idle", busy2, 0);
    #1 r2_valid = 1'b1;
    @(negedge clk); t = cyc; #1 r2_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("d2_done", done2, 1); chk("d2_ch", dch2, 4); chk("d2_coil", coil2, 5'b10000);
    @(negedge clk);
    chk("d2_sw", sw2, 5'b10000); chk("d2_done_low", done2, 0); chk("d2_err", err2, 1);
`ifdef RELAY_SEQ_MUTEX_EN
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    req(2'd0, 1'b1, t);
    wait_idle();
    dq.delete(); dc.delete();
    req(2'd2, 1'b1, t);
    repeat (2) @(negedge clk); chk("mx_break", coil_drv, 4'b0000);
    repeat (15) @(negedge clk); chk("mx_hold_coil", coil_drv, 4'b0000); chk("mx_hold_sw", sw_state, 4'b0001);
    @(negedge clk); chk("mx_make_coil", coil_drv, 4'b0100); chk("mx_make_sw", sw_state, 4'b0000);
    wait_idle();
    chk("mx_count", dq.size(), 1);
    if (dq.size() == 1) begin chk("mx_ch", dq[0], 2); chk("mx_cyc", dc[0], t + 2 + 2 * S); end
    chk("mx_sw", sw_state, 4'b0100);
`endif
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("final_err2", err2, 0); chk("final_coil", coil_drv, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
